// File: rtl/sample_demux_8.sv
// Packet demultiplexer: routes whole input packets into one of two FWFT byte FIFOs (A/B).
// Optional per-channel accepted-byte counters when DEMUX_STATS_EN is defined.

module sample_demux_8_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [8:0] wdata_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [8:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]  head_q, head_d;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
    // The incoming byte becomes the head when it lands exactly at the new read pointer.
    if (push_i && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end
endmodule

module sample_demux_8 #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_sel,
  output logic        in_ready,
  output logic [7:0]  a_data,
  output logic        a_valid,
  input  logic        a_ready,
  output logic        a_last,
  output logic [7:0]  b_data,
  output logic        b_valid,
  input  logic        b_ready,
`ifdef DEMUX_STATS_EN
  output logic [15:0] a_count,
  output logic [15:0] b_count,
`endif
  output logic        b_last
);
  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B} state_t;

  state_t     state_q;
  logic       live_q;
  logic       sel_a;
  logic       a_full, a_empty, b_full, b_empty;
  logic       accept, push_a, push_b, pop_a, pop_b;
  logic [8:0] a_head, b_head;

  // Channel choice: live in_sel between packets, locked channel inside a packet.
  assign sel_a    = (state_q == IDLE) ? in_sel : (state_q == ROUTE_A);
  assign in_ready = live_q & ~(sel_a ? a_full : b_full);
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & sel_a;
  assign push_b   = accept & ~sel_a;

  assign a_valid  = ~a_empty;
  assign b_valid  = ~b_empty;
  assign pop_a    = a_valid & a_ready;
  assign pop_b    = b_valid & b_ready;
  assign a_data   = a_head[7:0];
  assign a_last   = a_head[8];
  assign b_data   = b_head[7:0];
  assign b_last   = b_head[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        case (state_q)
          IDLE:    if (!in_last) state_q <= in_sel ? ROUTE_A : ROUTE_B;
          ROUTE_A: if (in_last)  state_q <= IDLE;
          ROUTE_B: if (in_last)  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sample_demux_8_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a),
    .wdata_i ({in_last, in_data}),
    .pop_i   (pop_a),
    .full_o  (a_full),
    .empty_o (a_empty),
    .head_o  (a_head)
  );

  sample_demux_8_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b),
    .wdata_i ({in_last, in_data}),
    .pop_i   (pop_b),
    .full_o  (b_full),
    .empty_o (b_empty),
    .head_o  (b_head)
  );

`ifdef DEMUX_STATS_EN
  logic [15:0] a_count_q, b_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (push_a) a_count_q <= a_count_q + 16'd1;
      if (push_b) b_count_q <= b_count_q + 16'd1;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif
endmodule

// File: tb/tb_sample_demux_8.sv
// Randomized and directed checks of sample_demux_8 against a queue-based packet-routing model.
module tb_sample_demux_8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_last = 1'b0, in_sel = 1'b0;
  logic        in_ready;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid, a_last, b_last;
  logic        a_ready = 1'b0, b_ready = 1'b0;
`ifdef DEMUX_STATS_EN
  logic [15:0] a_count, b_count;
`endif

  sample_demux_8 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_sel(in_sel), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
`ifdef DEMUX_STATS_EN
    .a_count(a_count), .b_count(b_count),
`endif
    .b_last(b_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: per-channel queues of {last,data}, current packet owner (0 none, 1 A, 2 B).
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int         owner = 0;
  bit         alive = 0;
  int         cnt_a = 0, cnt_b = 0;

  logic       obs_rdy, obs_av, obs_al, obs_bv, obs_bl;
  logic [7:0] obs_ad, obs_bd;
  logic [15:0] obs_ac;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit s,
                      input bit ar, input bit br);
    bit tgt_a, exp_rdy, acc;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; in_sel = s; a_ready = ar; b_ready = br;
    #1;
    tgt_a   = (owner == 0) ? s : (owner == 1);
    exp_rdy = alive && ((tgt_a ? qa.size() : qb.size()) < DEPTH);
    obs_rdy = in_ready; obs_av = a_valid; obs_ad = a_data; obs_al = a_last;
    obs_bv = b_valid; obs_bd = b_data; obs_bl = b_last;
    chk("in_ready", in_ready, exp_rdy);
    chk("a_valid", a_valid, qa.size() != 0);
    chk("b_valid", b_valid, qb.size() != 0);
    if (qa.size() != 0) begin
      chk("a_data", a_data, qa[0][7:0]);
      chk("a_last", a_last, qa[0][8]);
    end
    if (qb.size() != 0) begin
      chk("b_data", b_data, qb[0][7:0]);
      chk("b_last", b_last, qb[0][8]);
    end
`ifdef DEMUX_STATS_EN
    obs_ac = a_count;
    chk("a_count", a_count, cnt_a);
    chk("b_count", b_count, cnt_b);
`else
    obs_ac = 16'h0;
`endif
    acc = v && exp_rdy;
    if (ar && qa.size() != 0) void'(qa.pop_front());
    if (br && qb.size() != 0) void'(qb.pop_front());
    if (acc) begin
      if (tgt_a) begin qa.push_back({l, d}); cnt_a = (cnt_a + 1) % 65536; end
      else       begin qb.push_back({l, d}); cnt_b = (cnt_b + 1) % 65536; end
      if (owner == 0) owner = l ? 0 : (s ? 1 : 2);
      else if (l) owner = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst a_valid", a_valid, 0);
    chk("rst b_valid", b_valid, 0);
    chk("rst a_last", a_last, 0);
    chk("rst b_last", b_last, 0);
    chk("rst a_data", a_data, 0);
    chk("rst b_data", b_data, 0);
    qa.delete(); qb.delete(); owner = 0; alive = 0; cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel in_ready pre-edge", in_ready, 0);
    alive = 1;
  endtask

  logic [7:0] drained[$];

  initial begin
    do_reset();

    // 3-byte packet to A
    step(1, 8'h11, 0, 1, 1, 1);
    chk("p1 a_valid c0", obs_av, 0);
    step(1, 8'h22, 0, 0, 1, 1);
    chk("p1 a_data c1", obs_ad, 8'h11);
    chk("p1 a_valid c1", obs_av, 1);
    step(1, 8'h33, 1, 0, 1, 1);
    chk("p1 a_data c2", obs_ad, 8'h22);
    chk("p1 a_last c2", obs_al, 0);
    step(0, 8'h00, 0, 0, 1, 1);
    chk("p1 a_data c3", obs_ad, 8'h33);
    chk("p1 a_last c3", obs_al, 1);
    chk("p1 b_valid c3", obs_bv, 0);
    step(0, 8'h00, 0, 0, 1, 1);
    chk("p1 a_valid c4", obs_av, 0);

    // Packet starting on B with in_sel toggling to 1 mid-packet
    step(1, 8'h40, 0, 0, 1, 1);
    step(1, 8'h41, 0, 1, 1, 1);
    step(1, 8'h42, 1, 1, 1, 1);
    chk("toggle a_valid", obs_av, 0);
    step(0, 8'h00, 0, 0, 1, 1);
    chk("toggle b_data", obs_bd, 8'h42);
    chk("toggle a_valid2", obs_av, 0);

    // B stalled: fill with 5 bytes
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'h05, 1, 1, 0, 0);
    chk("b full in_ready", obs_rdy, 0);
    step(1, 8'h05, 1, 1, 0, 1);
    chk("b full in_ready2", obs_rdy, 0);
    if (obs_bv) drained.push_back(obs_bd);
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 8'h05, 1, 1, 0, 1);
      if (obs_bv) drained.push_back(obs_bd);
    end
    chk("b drain count", drained.size(), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++) chk("b drain order", drained[i], i + 1);

    // B full and stalled; A packet still flows with 1-cycle latency
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), i == 3, 0, 1, 0);
    step(1, 8'hA0, 0, 1, 1, 0);
    chk("a path ready", obs_rdy, 1);
    step(1, 8'hA1, 1, 0, 1, 0);
    chk("a latency valid", obs_av, 1);
    chk("a latency data", obs_ad, 8'hA0);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("a second data", obs_ad, 8'hA1);
    chk("b still stalled", obs_bv, 1);

    // Reset mid A packet
    do_reset();
    step(1, 8'hC0, 0, 1, 0, 0);
    step(1, 8'hC1, 0, 1, 0, 0);
    do_reset();
    step(1, 8'hD0, 1, 0, 1, 1);
    step(0, 8'h00, 0, 0, 1, 1);
    chk("post-rst b_valid", obs_bv, 1);
    chk("post-rst b_data", obs_bd, 8'hD0);
    chk("post-rst a_valid", obs_av, 0);

    // Randomized traffic with varying back-pressure
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 600; i++) begin
        step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
             1'($urandom), $urandom_range(0, 3) > phase, $urandom_range(0, 3) >= phase);
      end
      if (phase == 1) do_reset();
    end

`ifdef DEMUX_STATS_EN
    do_reset();
    for (int i = 0; i < 65537; i++) step(1, 8'(i), (i % 8) == 7, 1, 1, 1);
    step(0, 8'h00, 0, 0, 1, 1);
    chk("a_count wrap", obs_ac, 16'd1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sample_demux_8.md
SAMPLE_DEMUX_8 -- requirements
Module: sample_demux_8

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting per-channel FIFO depth in bytes (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_data, input, 8, incoming sample byte.
REQ-005 The block SHALL have port in_valid, input, 1, in_data valid.
REQ-006 The block SHALL have port in_last, input, 1, final byte of the current packet.
REQ-007 The block SHALL have port in_sel, input, 1, destination select (1 = A, 0 = B), sampled on the first beat of a packet only.
REQ-008 The block SHALL have port in_ready, output, 1, byte accepted when in_valid and in_ready are both high.
REQ-009 The block SHALL have ports a_data/b_data, output, 8, channel output bytes.
REQ-010 The block SHALL have ports a_valid/b_valid, output, 1, channel output valid.
REQ-011 The block SHALL have ports a_ready/b_ready, input, 1, channel consumer ready.
REQ-012 The block SHALL have ports a_last/b_last, output, 1, packet end flag travelling with each byte.

Function
REQ-013 The block SHALL implement FSM states IDLE, ROUTE_A and ROUTE_B.
REQ-014 The block SHALL, in IDLE, on an accepted beat, write that beat to FIFO A if in_sel=1 and to FIFO B if in_sel=0, and enter ROUTE_A or ROUTE_B respectively, unless in_last=1, in which case it stays in IDLE.
REQ-015 The block SHALL, in ROUTE_x, write each accepted beat to FIFO x, ignore in_sel, and return to IDLE on an accepted beat with in_last=1.
REQ-016 The block SHALL drive in_ready = not-full of FIFO A or B, chosen by in_sel in IDLE and by the locked channel in ROUTE_x; it SHALL be combinational with no dependence on in_valid.
REQ-017 Each FIFO SHALL store {last, data} with DEPTH entries and log2(DEPTH)+1-bit wrapping pointers; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-018 x_valid SHALL equal FIFO x not-empty; x_data/x_last SHALL present the head entry registered (first-word-fall-through), popped on x_valid and x_ready.
REQ-019 Latency from an accepted input beat to x_valid SHALL be exactly 1 cycle when FIFO x was empty.
REQ-020 A simultaneous push and pop on a full FIFO SHALL not occur (in_ready is low); a simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the count unchanged.
REQ-021 Channels SHALL be independent: a stalled channel SHALL NOT block the other channel's output drain.
REQ-022 Data SHALL exit each channel in acceptance order with no loss or duplication.

Reset
REQ-023 Asserting rst_n low SHALL immediately clear the FSM to IDLE, clear all pointers, and drive in_ready=0, a_valid=b_valid=0, a_last=b_last=0, a_data=b_data=8'h00.
REQ-024 Reset asserted mid-packet SHALL discard all buffered bytes and the locked channel; the first beat after release is treated as a new packet.
REQ-025 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-026 With DEMUX_STATS_EN defined, the block SHALL add outputs a_count and b_count, 16 bits each, counting accepted bytes per channel, wrapping at 16'hFFFF to 0, and reset to 0.
REQ-027 Without DEMUX_STATS_EN, the block SHALL omit those ports and counters, with no other behavioural change.

Verification
REQ-028 Reset, then a 3-byte packet 8'h11,8'h22,8'h33 (in_sel=1 on the first beat, last on the third) with a_ready=1 -> a_data sequence 11,22,33 with a_last only on 33; b_valid stays 0.
REQ-029 A packet starting with in_sel=0 where in_sel toggles to 1 mid-packet -> all bytes appear on B only.
REQ-030 DEPTH=4 with b_ready=0, push 5 bytes to B -> in_ready=0 after the 4th byte; after b_ready=1 all 5 bytes drain in order.
REQ-031 B full and stalled while an A packet is offered -> A bytes flow with 1-cycle latency.
REQ-032 rst_n pulsed low after 2 of 4 beats of an A packet -> a_valid=0 immediately; the next beat with in_sel=0 goes to B.
REQ-033 With DEMUX_STATS_EN defined, 65537 bytes sent to A -> a_count=1.
